snake_dir_ctrl: RTL and testbench

//  Multi-player snake steering and game-state controller. Sits between the one-pulse button debouncers and the snake datapath.

---
 rtl/snake_pkg.sv | 23 ++
 rtl/dir_queue.sv | 69 ++++++
 rtl/snake_dir_ctrl.sv | 76 +++++++
 tb/tb_snake_dir_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/game-state encodings and steering helpers for snake_dir_ctrl.
package snake_pkg;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_PLAY  = 2'd1,
        GS_OVER  = 2'd2,
        GS_PAUSE = 2'd3
    } game_state_e;

    // Encodings pair up so the low bit flips a heading to its opposite.
    function automatic logic [1:0] mirror_dir(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

    function automatic logic same_axis(input logic [1:0] a, input logic [1:0] b);
        return a[1] == b[1];
    endfunction
endpackage

// File: rtl/dir_queue.sv
// dir_queue: one player's press mirroring, turn filtering, turn FIFO and heading register.
module dir_queue
    import snake_pkg::*;
#(
    parameter int         QDEPTH   = 2,
    parameter logic [1:0] INIT_DIR = DIR_RIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       opposite_i,
    input  logic       accept_i,
    input  logic       step_i,
    input  logic       flush_i,
    input  logic       init_i,
    output logic [1:0] dir_o,
    output logic       pending_o
);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [1:0]    q_q [QDEPTH];
    logic [1:0]    q_d [QDEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dir_q, dir_d;
    logic          mu, md, ml, mr, any_press, push, pop;
    logic [1:0]    cand, tail;
    int            wr;

    assign mu        = opposite_i ? down_i  : up_i;
    assign md        = opposite_i ? up_i    : down_i;
    assign ml        = opposite_i ? right_i : left_i;
    assign mr        = opposite_i ? left_i  : right_i;
    assign any_press = mu | md | ml | mr;
    assign cand      = mu ? DIR_UP : md ? DIR_DOWN : ml ? DIR_LEFT : DIR_RIGHT;

    // Head lives at index 0; a pop shifts the queue down one slot.
    always_comb begin
        tail = dir_q;
        for (int k = 0; k < QDEPTH; k++)
            if (int'(cnt_q) - 1 == k) tail = q_q[k];
        pop  = step_i & (cnt_q != '0);
        push = accept_i & any_press & ~same_axis(cand, tail) & ((int'(cnt_q) < QDEPTH) | pop);
        wr   = int'(cnt_q) - int'(pop);
        for (int k = 0; k < QDEPTH; k++) begin
            q_d[k] = pop ? q_q[(k + 1) % QDEPTH] : q_q[k];
            if (push && k == wr) q_d[k] = cand;
        end
        cnt_d = (flush_i | init_i) ? '0 : cnt_q + CW'(push) - CW'(pop);
        dir_d = init_i ? INIT_DIR : flush_i ? dir_q : pop ? q_q[0] : dir_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dir_q <= INIT_DIR;
            for (int k = 0; k < QDEPTH; k++) q_q[k] <= DIR_UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            for (int k = 0; k < QDEPTH; k++) q_q[k] <= q_d[k];
        end
    end

    assign dir_o     = dir_q;
    assign pending_o = cnt_q != '0;
endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: multi-player snake steering with per-player turn queues and the game FSM.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int                       N_PLAYERS = 2,
    parameter int                       QDEPTH    = 2,
    parameter logic [2*N_PLAYERS-1:0]   INIT_DIRS = 4'b1011
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PLAYERS-1:0]   btn_up,
    input  logic [N_PLAYERS-1:0]   btn_down,
    input  logic [N_PLAYERS-1:0]   btn_left,
    input  logic [N_PLAYERS-1:0]   btn_right,
    input  logic [N_PLAYERS-1:0]   opposite,
    input  logic                   btn_start,
    input  logic                   btn_pause,
    input  logic                   move_tick,
    input  logic                   gameover,
    input  logic                   blink,
    output logic [2*N_PLAYERS-1:0] direction,
    output logic [N_PLAYERS-1:0]   turn_pending,
    output logic [1:0]             game_state,
    output logic                   gaming,
    output logic                   score_zero,
    output logic                   led_play
);
    game_state_e state_q;
    logic        play, enter_over, enter_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= GS_IDLE;
        else begin
            case (state_q)
                GS_IDLE:  if (btn_start) state_q <= GS_PLAY;
                GS_PLAY:  state_q <= gameover ? GS_OVER : btn_pause ? GS_PAUSE : GS_PLAY;
                GS_PAUSE: state_q <= gameover ? GS_OVER : btn_pause ? GS_PLAY : GS_PAUSE;
                GS_OVER:  if (btn_start) state_q <= GS_IDLE;
                default:  state_q <= GS_IDLE;
            endcase
        end
    end

    assign play       = state_q == GS_PLAY;
    assign enter_over = (state_q == GS_PLAY || state_q == GS_PAUSE) && gameover;
    assign enter_idle = state_q == GS_OVER && btn_start;

    genvar g;
    generate
        for (g = 0; g < N_PLAYERS; g++) begin : g_player
            dir_queue #(
                .QDEPTH  (QDEPTH),
                .INIT_DIR(INIT_DIRS[2*g +: 2])
            ) u_q (
                .clk       (clk),
                .rst       (rst),
                .up_i      (btn_up[g]),
                .down_i    (btn_down[g]),
                .left_i    (btn_left[g]),
                .right_i   (btn_right[g]),
                .opposite_i(opposite[g]),
                .accept_i  (play),
                .step_i    (play & move_tick),
                .flush_i   (enter_over),
                .init_i    (enter_idle),
                .dir_o     (direction[2*g +: 2]),
                .pending_o (turn_pending[g])
            );
        end
    endgenerate

    assign game_state = state_q;
    assign gaming     = state_q == GS_PLAY;
    assign score_zero = state_q == GS_IDLE;
    assign led_play   = (state_q == GS_OVER) & blink;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed scenarios for steering, queueing and the game FSM.
module tb_snake_dir_ctrl;
    logic       clk = 0, rst = 1;
    logic [1:0] btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, opposite = 0;
    logic       btn_start = 0, btn_pause = 0, move_tick = 0, gameover = 0, blink = 0;
    logic [3:0] direction;
    logic [1:0] turn_pending, game_state;
    logic       gaming, score_zero, led_play;
    int         nvec = 0, nerr = 0;

    snake_dir_ctrl dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .opposite(opposite), .btn_start(btn_start), .btn_pause(btn_pause),
        .move_tick(move_tick), .gameover(gameover), .blink(blink), .direction(direction),
        .turn_pending(turn_pending), .game_state(game_state), .gaming(gaming),
        .score_zero(score_zero), .led_play(led_play)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_start = 0; btn_pause = 0; move_tick = 0; gameover = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (game_state !== 2'd0) begin nerr++; $display("FAIL reset_state got %0d exp 0", game_state); end
        nvec++; if (direction !== 4'b1011) begin nerr++; $display("FAIL reset_dir got %b exp 1011", direction); end
        nvec++; if ({gaming, score_zero, led_play, turn_pending} !== 5'b01000) begin nerr++; $display("FAIL reset_flags got %b exp 01000", {gaming, score_zero, led_play, turn_pending}); end
        rst = 0;
        cyc();
    endtask

    task automatic test_start();
        btn_start = 1; cyc();
        nvec++; if (game_state !== 2'd1) begin nerr++; $display("FAIL start_state got %0d exp 1", game_state); end
        nvec++; if ({gaming, score_zero} !== 2'b10) begin nerr++; $display("FAIL start_flags got %b exp 10", {gaming, score_zero}); end
        nvec++; if (direction !== 4'b1011) begin nerr++; $display("FAIL start_dir got %b exp 1011", direction); end
    endtask

    task automatic test_queue();
        btn_up = 2'b01; cyc();
        nvec++; if (turn_pending !== 2'b01) begin nerr++; $display("FAIL queue_pending got %b exp 01", turn_pending); end
        btn_left = 2'b01; cyc();
        move_tick = 1; cyc();
        nvec++; if (direction !== 4'b1000) begin nerr++; $display("FAIL queue_tick1 got %b exp 1000", direction); end
        nvec++; if (turn_pending !== 2'b01) begin nerr++; $display("FAIL queue_left_held got %b exp 01", turn_pending); end
        move_tick = 1; cyc();
        nvec++; if (direction !== 4'b1010) begin nerr++; $display("FAIL queue_tick2 got %b exp 1010", direction); end
        nvec++; if (turn_pending !== 2'b00) begin nerr++; $display("FAIL queue_empty got %b exp 00", turn_pending); end
    endtask

    task automatic test_reject();
        btn_up = 2'b01; cyc(); move_tick = 1; cyc();
        btn_right = 2'b01; cyc(); move_tick = 1; cyc();
        nvec++; if (direction !== 4'b1011) begin nerr++; $display("FAIL reject_setup got %b exp 1011", direction); end
        btn_left = 2'b01; cyc();
        nvec++; if (turn_pending !== 2'b00) begin nerr++; $display("FAIL reject_left got %b exp 00", turn_pending); end
        btn_right = 2'b01; cyc();
        nvec++; if (turn_pending !== 2'b00) begin nerr++; $display("FAIL reject_right got %b exp 00", turn_pending); end
        move_tick = 1; cyc();
        nvec++; if (direction !== 4'b1011) begin nerr++; $display("FAIL reject_hold got %b exp 1011", direction); end
    endtask

    task automatic test_opposite();
        opposite = 2'b01; btn_up = 2'b01; cyc();
        opposite = 2'b00;
        nvec++; if (turn_pending !== 2'b01) begin nerr++; $display("FAIL opp_pending got %b exp 01", turn_pending); end
        move_tick = 1; cyc();
        nvec++; if (direction !== 4'b1001) begin nerr++; $display("FAIL opp_down got %b exp 1001", direction); end
    endtask

    task automatic test_full();
        btn_left = 2'b01; cyc(); btn_up = 2'b01; cyc(); btn_right = 2'b01; cyc();
        move_tick = 1; cyc();
        nvec++; if (direction !== 4'b1010) begin nerr++; $display("FAIL full_tick1 got %b exp 1010", direction); end
        move_tick = 1; cyc();
        nvec++; if (direction !== 4'b1000) begin nerr++; $display("FAIL full_tick2 got %b exp 1000", direction); end
        nvec++; if (turn_pending !== 2'b00) begin nerr++; $display("FAIL full_dropped got %b exp 00", turn_pending); end
        btn_left = 2'b01; cyc(); btn_down = 2'b01; cyc();
        btn_right = 2'b01; move_tick = 1; cyc();
        nvec++; if ({direction, turn_pending} !== 6'b101001) begin nerr++; $display("FAIL b2b_tick got %b exp 101001", {direction, turn_pending}); end
        move_tick = 1; cyc();
        nvec++; if ({direction, turn_pending} !== 6'b100101) begin nerr++; $display("FAIL b2b_second got %b exp 100101", {direction, turn_pending}); end
        move_tick = 1; cyc();
        nvec++; if ({direction, turn_pending} !== 6'b101100) begin nerr++; $display("FAIL b2b_third got %b exp 101100", {direction, turn_pending}); end
    endtask

    task automatic test_priority();
        btn_up = 2'b01; btn_left = 2'b01; btn_down = 2'b10; cyc();
        nvec++; if (turn_pending !== 2'b11) begin nerr++; $display("FAIL prio_pending got %b exp 11", turn_pending); end
        move_tick = 1; cyc();
        nvec++; if (direction !== 4'b0100) begin nerr++; $display("FAIL prio_dir got %b exp 0100", direction); end
        nvec++; if (turn_pending !== 2'b00) begin nerr++; $display("FAIL prio_drop got %b exp 00", turn_pending); end
    endtask

    task automatic test_pause();
        btn_pause = 1; cyc();
        nvec++; if ({game_state, gaming} !== 3'b110) begin nerr++; $display("FAIL pause_state got %b exp 110", {game_state, gaming}); end
        btn_left = 2'b01; cyc();
        nvec++; if (turn_pending !== 2'b00) begin nerr++; $display("FAIL pause_press got %b exp 00", turn_pending); end
        move_tick = 1; btn_start = 1; cyc();
        nvec++; if ({game_state, direction} !== 6'b110100) begin nerr++; $display("FAIL pause_hold got %b exp 110100", {game_state, direction}); end
        btn_pause = 1; cyc();
        nvec++; if (game_state !== 2'd1) begin nerr++; $display("FAIL unpause got %0d exp 1", game_state); end
    endtask

    task automatic test_over();
        btn_left = 2'b01; cyc();
        nvec++; if (turn_pending !== 2'b01) begin nerr++; $display("FAIL over_setup got %b exp 01", turn_pending); end
        gameover = 1; btn_pause = 1; blink = 1; cyc();
        nvec++; if ({game_state, turn_pending, direction} !== 8'b10000100) begin nerr++; $display("FAIL over_enter got %b exp 10000100", {game_state, turn_pending, direction}); end
        nvec++; if (led_play !== 1'b1) begin nerr++; $display("FAIL over_led_on got %b exp 1", led_play); end
        blink = 0; #1;
        nvec++; if (led_play !== 1'b0) begin nerr++; $display("FAIL over_led_off got %b exp 0", led_play); end
        gameover = 1; cyc();
        nvec++; if (game_state !== 2'd2) begin nerr++; $display("FAIL over_hold got %0d exp 2", game_state); end
        btn_start = 1; cyc();
        nvec++; if ({game_state, score_zero, direction} !== 7'b0011011) begin nerr++; $display("FAIL over_idle got %b exp 0011011", {game_state, score_zero, direction}); end
        gameover = 1; blink = 1; cyc();
        nvec++; if ({game_state, led_play} !== 3'b000) begin nerr++; $display("FAIL idle_ignore got %b exp 000", {game_state, led_play}); end
        blink = 0;
    endtask

    task automatic test_mid_reset();
        btn_start = 1; cyc();
        btn_up = 2'b11; cyc();
        move_tick = 1; cyc();
        nvec++; if (direction !== 4'b0000) begin nerr++; $display("FAIL midrst_setup got %b exp 0000", direction); end
        btn_left = 2'b01; cyc();
        #2 rst = 1; #1;
        nvec++; if ({game_state, turn_pending, direction} !== 8'b00001011) begin nerr++; $display("FAIL midrst_async got %b exp 00001011", {game_state, turn_pending, direction}); end
        cyc(); rst = 0; cyc();
        nvec++; if ({game_state, score_zero} !== 3'b001) begin nerr++; $display("FAIL midrst_after got %b exp 001", {game_state, score_zero}); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_queue();
        test_reject();
        test_opposite();
        test_full();
        test_priority();
        test_pause();
        test_over();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
